match_event_counter: RTL
========================

Name: match_event_counter

Overview:
- Sits directly downstream of the serial pattern detector and consumes its one-cycle match flag `q`.
- Counts matches over fixed, back-to-back observation windows of WIN_LEN clock cycles.
- At the end of each window it publishes the count, plus a threshold alarm, on a valid/ready result port.
- Result overwrites are flagged with a sticky overrun bit, so system logic can rate-monitor detected frames.

Parameters:
- CNT_W, 8: width of the match count. Saturates at 2^CNT_W-1.
- WIN_W, 8: width of the window cycle counter. Must hold WIN_LEN-1.
- WIN_LEN, 64: window length in clock cycles. Legal range is 2 to 2^WIN_W.
- THRESH, 4: alarm threshold. res_alarm is set when the window count is >= THRESH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  counting enable.
- clr  input  1  synchronous clear of result and overrun, active-high.
- q_in  input  1  match flag from the detector; each high cycle is one match.
- res_ready  input  1  consumer accepts the result.
- res_valid  output  1  result available.
- res_cnt  output  CNT_W  match count of the last completed window.
- res_alarm  output  1  set when res_cnt >= THRESH; qualified by res_valid.
- overrun  output  1  sticky; an unaccepted result was overwritten.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, win_cnt=0, acc=0.
  - res_valid=0, res_cnt=0, res_alarm=0, overrun=0.
  - Takes effect immediately, including mid-window and while a result is pending.
- FSM states are IDLE and RUN:
  - IDLE: q_in is ignored; win_cnt=0, acc=0. en=1 -> RUN on the next edge. The first RUN cycle is window cycle 0.
  - RUN, en=1: win_cnt increments every cycle. If q_in=1, acc increments, saturating at 2^CNT_W-1 with no wrap.
  - RUN, en=0: -> IDLE on the next edge. The partial window is discarded and no result is produced. res_valid, res_cnt and overrun are unaffected.
- Window end (RUN, win_cnt==WIN_LEN-1):
  - final = sat(acc + q_in). The q_in of the last cycle is counted.
  - On the next edge: res_cnt=final, res_alarm=(final>=THRESH), res_valid=1.
  - On the same edge: win_cnt=0 and acc=0.
  - Windows run back-to-back with no dead cycle. Result latency is 1 cycle after the last window cycle.
- Handshake:
  - A transfer occurs on a cycle where res_valid=1 and res_ready=1. res_valid falls on the next edge unless a new result loads on that same edge.
  - res_cnt and res_alarm stay stable while res_valid=1 and no new window ends.
  - res_ready is ignored when res_valid=0.
- Simultaneous window end and transfer: the new result loads, res_valid stays 1, overrun is not set.
- Window end while res_valid=1 and res_ready=0: the result is overwritten with the new window's value and overrun is set. overrun stays set until reset or clr.
- clr=1 (synchronous):
  - res_valid=0 and overrun=0 on the next edge.
  - win_cnt=0 and acc=0, so the current window restarts. FSM state is unchanged.
  - clr has priority over a coincident window end, whose result is discarded.
- en and clr in the same cycle: clr effects apply; the en transition applies as normal.

Test Plan:
(Bench parameters: CNT_W=4, WIN_LEN=8, THRESH=2, unless stated otherwise.)
- Reset: assert rst=0 with random inputs -> all outputs 0 immediately. Release, keep en=0, pulse q_in -> res_valid stays 0 indefinitely.
- Basic window: en=1, res_ready=1, q_in=1 at window cycles 1 and 7 -> res_valid=1 exactly 1 cycle after cycle 7, res_cnt=2, res_alarm=1, then res_valid=0 next cycle. Next window with a single pulse at cycle 0 -> res_cnt=1, res_alarm=0.
- Saturation: WIN_LEN=20, q_in held at 1 for the whole window -> res_cnt=15, with no wrap to 4.
- Overrun and simultaneous events:
  - res_ready=0; window 1 has 1 match, window 2 has 3 matches -> res_cnt=3, overrun=1, res_valid=1.
  - Raise res_ready exactly on the window-3 end cycle -> window-3 result loads, res_valid stays 1, overrun stays 1.
  - Pulse clr -> overrun=0, res_valid=0.
- Abort: 3 pulses, then en=0 at window cycle 5 -> no result. Re-enable, 1 pulse -> res_cnt=1 (not 4), res_alarm=0.
- Reset mid-operation: res_valid=1 and a window half counted, assert rst=0 -> all outputs 0 asynchronously before the next edge. After release with en=1 the window restarts at cycle 0.

Source files
------------

// File: rtl/match_event_counter.sv
// match_event_counter
// Counts one-cycle match flags from the serial pattern detector over fixed,
// back-to-back windows of WIN_LEN cycles. At each window end the count and a
// threshold alarm are published on a valid/ready result port. A result that
// is replaced before being accepted sets a sticky overrun flag.
module match_event_counter #(
    parameter int CNT_W   = 8,
    parameter int WIN_W   = 8,
    parameter int WIN_LEN = 64,
    parameter int THRESH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             q_in,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_cnt,
    output logic             res_alarm,
    output logic             overrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Last cycle index of a window; the window ends on the cycle holding it.
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic             inc);
        logic [CNT_W-1:0] res;
        if (inc && (val != {CNT_W{1'b1}})) begin
            res = val + CNT_W'(1);
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Alarm decision; a threshold above the count range simply never fires.
    function automatic logic over_thresh(input logic [CNT_W-1:0] val);
        logic [31:0] wide;
        wide = 32'(val);
        return (wide >= 32'(THRESH));
    endfunction

    state_t           state_r;
    logic [WIN_W-1:0] win_cnt_r;
    logic [CNT_W-1:0] acc_r;
    logic             res_valid_r;
    logic [CNT_W-1:0] res_cnt_r;
    logic             res_alarm_r;
    logic             overrun_r;

    logic             run_s;
    logic             win_end_s;
    logic             xfer_s;
    logic [CNT_W-1:0] final_s;
    logic             alarm_s;

    // Counting only happens while in RUN with en held high; en=0 aborts.
    assign run_s     = (state_r == ST_RUN) && en;
    assign win_end_s = run_s && (win_cnt_r == WIN_LAST);
    assign xfer_s    = res_valid_r && res_ready;
    // The match flag of the current cycle is folded in, so the last window
    // cycle is counted in that window's result.
    assign final_s   = sat_inc(acc_r, q_in);
    assign alarm_s   = over_thresh(final_s);

    // Mode FSM: IDLE waits for en, RUN drops back to IDLE as soon as en falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Window cycle counter and match accumulator; cleared outside counting,
    // on clr and at every window end so windows abut with no dead cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt_r <= {WIN_W{1'b0}};
            acc_r     <= {CNT_W{1'b0}};
        end else if (clr || !run_s || win_end_s) begin
            win_cnt_r <= {WIN_W{1'b0}};
            acc_r     <= {CNT_W{1'b0}};
        end else begin
            win_cnt_r <= win_cnt_r + WIN_W'(1);
            acc_r     <= final_s;
        end
    end

    // Result register and handshake; clr wins over a coincident window end,
    // a new result wins over a coincident transfer, and replacing an
    // unaccepted result marks overrun until reset or clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_r <= 1'b0;
            res_cnt_r   <= {CNT_W{1'b0}};
            res_alarm_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (clr) begin
            res_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (win_end_s) begin
            res_valid_r <= 1'b1;
            res_cnt_r   <= final_s;
            res_alarm_r <= alarm_s;
            if (res_valid_r && !res_ready) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (xfer_s) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    assign res_valid = res_valid_r;
    assign res_cnt   = res_cnt_r;
    assign res_alarm = res_alarm_r;
    assign overrun   = overrun_r;

endmodule
